fetch_unit: RTL

Parametrised instruction fetch stage that replaces the fixed step-counter-plus-free-running-PC arrangement at the front of the CPU. Owns the program counter, issues reads to the synchronous instruction RAM, and presents each fetched instruction with its PC to decode over a valid/ready handshake. Supports redirects (branch/jump target load) from any state, discarding in-flight work.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_pc.sv | 36 +++
 rtl/fetch_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_VALID,
    ST_HALT
  } fetch_state_t;
endpackage

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter register; redirect load wins over sequential increment
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);
  logic [XLEN-1:0] pc_q, pc_d;

  // Increment wraps naturally at 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect; FETCH_MISALIGN_EN enables misaligned-fetch faults
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect,
  input  logic [XLEN-1:0]   target,
  output logic              mem_re,
  output logic [XLEN-3:0]   mem_addr,
  input  logic [INST_W-1:0] mem_dout,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault
);
  fetch_state_t      state_q, state_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              inst_fault_q, inst_fault_d;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   target_eff;
  logic              pc_load, pc_inc;
  logic              misaligned;

`ifdef FETCH_MISALIGN_EN
  assign target_eff = target;
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign target_eff = target & ~XLEN'(3);
  assign misaligned = 1'b0;
`endif

  fetch_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .resetn   (resetn),
    .load     (pc_load),
    .load_val (target_eff),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign mem_re   = (state_q == ST_ISSUE) && !misaligned;
  assign mem_addr = pc[XLEN-1:2];

  always_comb begin
    state_d      = state_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (misaligned) begin
          state_d      = ST_VALID;
          inst_valid_d = 1'b1;
          inst_fault_d = 1'b1;
          inst_d       = '0;
          inst_pc_d    = pc;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d      = ST_VALID;
        inst_valid_d = 1'b1;
        inst_fault_d = 1'b0;
        inst_d       = mem_dout;
        inst_pc_d    = pc;
        pc_inc       = 1'b1;
      end
      ST_VALID: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          inst_fault_d = 1'b0;
          state_d      = inst_fault_q ? ST_HALT : ST_ISSUE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // A redirect overrides everything above, including data returning in WAIT.
    if (redirect) begin
      state_d      = ST_ISSUE;
      inst_valid_d = 1'b0;
      inst_fault_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      pc_load      = 1'b1;
      pc_inc       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;
endmodule
